// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic int off_w(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int idx_w(input int nlines);
    return $clog2(nlines);
  endfunction

  // Byte offset bits [1:0] are never part of the tag.
  function automatic int tag_w(input int nlines, input int wpl);
    return 30 - $clog2(wpl) - $clog2(nlines);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Data and tag storage: one shared write port (index from the fill line), one async read port.
module icache_array
  import icache_pkg::*;
#(
  parameter int NLINES = 16,
  parameter int WPL    = 4
) (
  input  logic                         clk,
  input  logic                         data_we,
  input  logic                         tag_we,
  input  logic [idx_w(NLINES)-1:0]     widx,
  input  logic [off_w(WPL)-1:0]        woff,
  input  logic [31:0]                  wdata,
  input  logic [tag_w(NLINES,WPL)-1:0] wtag,
  input  logic [idx_w(NLINES)-1:0]     ridx,
  input  logic [off_w(WPL)-1:0]        roff,
  output logic [31:0]                  rdata,
  output logic [tag_w(NLINES,WPL)-1:0] rtag
);

  localparam int TW = tag_w(NLINES, WPL);

  logic [31:0]   data_mem [NLINES*WPL];
  logic [TW-1:0] tag_mem  [NLINES];

  always_ff @(posedge clk) begin
    if (data_we) data_mem[{widx, woff}] <= wdata;
    if (tag_we)  tag_mem[widx]          <= wtag;
  end

  assign rdata = data_mem[{ridx, roff}];
  assign rtag  = tag_mem[ridx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: hit path, line fill FSM, flush and perf counters.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int NLINES = 16,
  parameter int WPL    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_instr,
  output logic        cpu_hold,
  input  logic        flush,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [1:0]  dbg_state
);

  localparam int OW = off_w(WPL);
  localparam int IW = idx_w(NLINES);
  localparam int TW = tag_w(NLINES, WPL);
  localparam int LW = 30 - OW;

  state_e              state_q, state_d;
  logic [NLINES-1:0]   valid_q, valid_d;
  logic [OW-1:0]       cnt_q, cnt_d;
  logic [LW-1:0]       line_q, line_d;
  logic                mem_rd_q, mem_rd_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;

  logic [31:0]   rd_data;
  logic [TW-1:0] rd_tag;
  logic [IW-1:0] cpu_idx, lat_idx;
  logic [OW-1:0] cpu_off, cnt_inc;
  logic [TW-1:0] cpu_tag, lat_tag;
  logic [LW-1:0] cpu_line;
  logic          hit, data_we, tag_we;
  logic          hold_c;
  logic [31:0]   instr_c;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];
  assign cpu_line = cpu_addr[31:2+OW];
  assign cpu_off  = cpu_addr[2 +: OW];
  assign cpu_idx  = cpu_line[0 +: IW];
  assign cpu_tag  = cpu_line[LW-1 -: TW];
  // The fill always targets the latched line, never the live fetch address.
  assign lat_idx  = line_q[0 +: IW];
  assign lat_tag  = line_q[LW-1 -: TW];
  assign cnt_inc  = cnt_q + OW'(1);

  assign hit     = valid_q[cpu_idx] && (rd_tag == cpu_tag);
  assign data_we = (state_q == FILL) && mem_ack;
  assign tag_we  = (state_q == COMMIT);

  icache_array #(.NLINES(NLINES), .WPL(WPL)) u_array (
    .clk     (clk),
    .data_we (data_we),
    .tag_we  (tag_we),
    .widx    (lat_idx),
    .woff    (cnt_q),
    .wdata   (mem_data),
    .wtag    (lat_tag),
    .ridx    (cpu_idx),
    .roff    (cpu_off),
    .rdata   (rd_data),
    .rtag    (rd_tag)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    hold_c     = 1'b1;
    instr_c    = 32'd0;
    case (state_q)
      IDLE: begin
        // A flush cycle stalls and skips hit/miss evaluation entirely.
        if (flush) begin
          valid_d = '0;
        end else if (hit) begin
          hold_c    = 1'b0;
          instr_c   = rd_data;
          hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
          line_d     = cpu_line;
          cnt_d      = '0;
          mem_rd_d   = 1'b1;
          mem_addr_d = {cpu_line, {OW{1'b0}}, 2'b00};
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          cnt_d      = cnt_inc;
          mem_addr_d = {line_q, cnt_inc, 2'b00};
          if (cnt_q == OW'(WPL - 1)) begin
            mem_rd_d = 1'b0;
            state_d  = COMMIT;
          end
        end
      end
      COMMIT: begin
        valid_d[lat_idx] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign cpu_hold  = hold_c;
  assign cpu_instr = instr_c;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign dbg_state = state_q;

endmodule
